// File: rtl/key_event_pkg.sv
// Shared types for the key event scheduler: event codes, per-key debounce
// states and the event record stored in the event queue.
package key_event_pkg;

  typedef logic [1:0] ev_code_t;

  localparam ev_code_t EV_PRESS   = 2'b01;
  localparam ev_code_t EV_RELEASE = 2'b10;
  localparam ev_code_t EV_LONG    = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Wide enough for the largest supported key count (16).
  localparam int KEY_W_MAX = 4;

  typedef struct packed {
    logic [KEY_W_MAX-1:0] key;
    ev_code_t             ev_type;
  } key_event_t;

  localparam int EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO with a valid/ready read side. Head data reads as
// zero while the queue is empty so the consumer never sees stale entries.
module event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop, push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_valid_o = !empty_o;
  assign pop        = rd_valid_o && rd_ready_i;
  assign push       = wr_en_i && (!full_o || pop);
  assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key debounce and press/release/long-press event scheduler: one shared
// sample tick, a round-robin scan servicing one key per clock, and an event queue.
module key_event_scheduler
  import key_event_pkg::*;
#(
  parameter  int N_KEYS     = 4,
  parameter  int TICK_DIV   = 50000,
  parameter  int DEB_TICKS  = 20,
  parameter  int LONG_TICKS = 1000,
  parameter  int FIFO_DEPTH = 4,
  localparam int KW         = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              Sys_clk,
  input  logic              Sys_reset,
  input  logic [N_KEYS-1:0] Pin_in,
  output logic [N_KEYS-1:0] Key_level,
  output logic              Ev_valid,
  input  logic              Ev_ready,
  output logic [KW-1:0]     Ev_key,
  output logic [1:0]        Ev_type,
  output logic              Ev_drop
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [CW-1:0]     div_q;
  logic              tick;
  logic              scan_act_q;
  logic [KW-1:0]     scan_idx_q;

  key_state_t        state_q [N_KEYS];
  logic [DW-1:0]     deb_q   [N_KEYS];
  logic [LW-1:0]     long_q  [N_KEYS];
  logic [N_KEYS-1:0] ldone_q, level_q;

  key_state_t    cur_st, st_d;
  logic [DW-1:0] cur_deb, deb_inc, deb_d;
  logic [LW-1:0] cur_long, long_d;
  logic          cur_s, cur_ld, ld_d, lvl_d;
  logic          ev_vld, ev_write, drop_q;
  ev_code_t      ev_code;

  key_event_t        wr_ev, head_ev;
  logic [EVENT_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty, fifo_pop;

  // Input synchronisers, sample-tick prescaler and scan sequencer.
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      div_q      <= '0;
      scan_act_q <= 1'b0;
      scan_idx_q <= '0;
    end else begin
      sync1_q <= Pin_in;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        scan_act_q <= 1'b1;
        scan_idx_q <= '0;
      end else if (scan_act_q) begin
        if (scan_idx_q == KW'(N_KEYS - 1)) begin
          scan_act_q <= 1'b0;
          scan_idx_q <= '0;
        end else begin
          scan_idx_q <= scan_idx_q + 1'b1;
        end
      end
    end
  end

  assign tick = (div_q == CW'(TICK_DIV - 1));

  assign cur_s    = sync2_q[scan_idx_q];
  assign cur_st   = state_q[scan_idx_q];
  assign cur_deb  = deb_q[scan_idx_q];
  assign cur_long = long_q[scan_idx_q];
  assign cur_ld   = ldone_q[scan_idx_q];
  assign deb_inc  = cur_deb + 1'b1;

  // Next state of the key currently under service.
  always_comb begin
    st_d    = cur_st;
    deb_d   = cur_deb;
    long_d  = cur_long;
    ld_d    = cur_ld;
    lvl_d   = level_q[scan_idx_q];
    ev_vld  = 1'b0;
    ev_code = EV_PRESS;
    case (cur_st)
      IDLE: begin
        if (cur_s) begin
          st_d  = PRESS_WAIT;
          deb_d = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!cur_s) begin
          st_d  = IDLE;
          deb_d = '0;
        end else if (deb_inc == DW'(DEB_TICKS)) begin
          st_d    = PRESSED;
          lvl_d   = 1'b1;
          ev_vld  = 1'b1;
          ev_code = EV_PRESS;
          deb_d   = '0;
          long_d  = '0;
          ld_d    = 1'b0;
        end else begin
          deb_d = deb_inc;
        end
      end
      PRESSED: begin
        if (!cur_s) begin
          st_d  = RELEASE_WAIT;
          deb_d = DW'(1);
        end else begin
          if (cur_long != LW'(LONG_TICKS)) long_d = cur_long + 1'b1;
          if ((long_d == LW'(LONG_TICKS)) && !cur_ld) begin
            ev_vld  = 1'b1;
            ev_code = EV_LONG;
            ld_d    = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        // A short release glitch returns here with long_cnt untouched.
        if (cur_s) begin
          st_d  = PRESSED;
          deb_d = '0;
        end else if (deb_inc == DW'(DEB_TICKS)) begin
          st_d    = IDLE;
          lvl_d   = 1'b0;
          ev_vld  = 1'b1;
          ev_code = EV_RELEASE;
          deb_d   = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= IDLE;
        deb_q[k]   <= '0;
        long_q[k]  <= '0;
      end
      ldone_q <= '0;
      level_q <= '0;
    end else if (scan_act_q) begin
      state_q[scan_idx_q] <= st_d;
      deb_q[scan_idx_q]   <= deb_d;
      long_q[scan_idx_q]  <= long_d;
      ldone_q[scan_idx_q] <= ld_d;
      level_q[scan_idx_q] <= lvl_d;
    end
  end

  assign ev_write = scan_act_q && ev_vld;
  assign wr_ev    = '{key: KEY_W_MAX'(scan_idx_q), ev_type: ev_code};
  assign fifo_pop = Ev_ready && !fifo_empty;

  event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (Sys_clk),
    .rst_n      (Sys_reset),
    .wr_en_i    (ev_write),
    .wr_data_i  (wr_ev),
    .rd_ready_i (Ev_ready),
    .rd_valid_o (Ev_valid),
    .rd_data_o  (fifo_rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Events are lost only when full and nothing leaves in the same cycle.
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      drop_q <= 1'b0;
    end else if (ev_write && fifo_full && !fifo_pop) begin
      drop_q <= 1'b1;
    end
  end

  assign head_ev   = key_event_t'(fifo_rd_data);
  assign Ev_key    = KW'(head_ev.key);
  assign Ev_type   = head_ev.ev_type;
  assign Ev_drop   = drop_q;
  assign Key_level = level_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler with N_KEYS=4, TICK_DIV=8, DEB_TICKS=3, LONG_TICKS=6.
module tb_key_event_scheduler;

  localparam logic [1:0] T_PRESS = 2'b01;
  localparam logic [1:0] T_REL   = 2'b10;
  localparam logic [1:0] T_LONG  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pins;
  logic [3:0] lvl;
  logic       ev_valid, ev_ready, ev_drop;
  logic [1:0] ev_key, ev_type;

  always #5 clk = ~clk;

  key_event_scheduler #(
    .N_KEYS     (4),
    .TICK_DIV   (8),
    .DEB_TICKS  (3),
    .LONG_TICKS (6),
    .FIFO_DEPTH (4)
  ) dut (
    .Sys_clk   (clk),
    .Sys_reset (rst_n),
    .Pin_in    (pins),
    .Key_level (lvl),
    .Ev_valid  (ev_valid),
    .Ev_ready  (ev_ready),
    .Ev_key    (ev_key),
    .Ev_type   (ev_type),
    .Ev_drop   (ev_drop)
  );

  // Clock edges since reset release; the prescaler phase is ph mod 8.
  int unsigned ph;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ph <= 0;
    else        ph <= ph + 1;

  typedef struct packed {
    logic [1:0] key;
    logic [1:0] typ;
  } ev_t;

  typedef struct {
    logic [3:0] pins;
    logic [3:0] lvl;
    int         n_ev;
    ev_t        e0;
    ev_t        e1;
  } vec_t;

  ev_t         sb[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned pop_ph[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] p, input logic [3:0] l, input int n = 0,
                              input logic [1:0] k0 = 2'd0, input logic [1:0] t0 = 2'd0,
                              input logic [1:0] k1 = 2'd0, input logic [1:0] t1 = 2'd0);
    vec_t v;
    v.pins = p;
    v.lvl  = l;
    v.n_ev = n;
    v.e0   = '{key: k0, typ: t0};
    v.e1   = '{key: k1, typ: t1};
    return v;
  endfunction

  // Scoreboard consumer: every accepted head event must match the next expectation.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=key%0d/type%0d required=none", ev_key, ev_type);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_key", 32'(ev_key), 32'(e.key));
        chk("ev_type", 32'(ev_type), 32'(e.typ));
        pop_ph[ev_key] = ph;
      end
    end
  end

  // One sample slot: drive pins right after the scan, wait for the next scan to finish.
  task automatic run_vec(input vec_t v, input bit drain, input string tag);
    if (v.n_ev > 0) sb.push_back(v.e0);
    if (v.n_ev > 1) sb.push_back(v.e1);
    if (ph % 8 != 5) begin
      @(negedge clk);
      while (ph % 8 != 5) @(negedge clk);
    end
    pins = v.pins;
    repeat (8) @(negedge clk);
    #3;
    chk({tag, " level"}, 32'(lvl), 32'(v.lvl));
    if (drain) chk({tag, " events"}, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pins     = 4'b0000;
    ev_ready = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("reset level", 32'(lvl), 0);
    chk("reset valid", 32'(ev_valid), 0);
    chk("reset key", 32'(ev_key), 0);
    chk("reset type", 32'(ev_type), 0);
    chk("reset drop", 32'(ev_drop), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean press on key 2, 20 samples held, then released.
    for (int i = 1; i <= 20; i++)
      vecs.push_back(mk(4'b0100, (i >= 3) ? 4'b0100 : 4'b0000, (i == 3 || i == 9) ? 1 : 0,
                        2'd2, (i == 3) ? T_PRESS : T_LONG));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(4'b0000, (i == 3) ? 4'b0000 : 4'b0100, (i == 3) ? 1 : 0, 2'd2, T_REL));
    // Bounce on key 0: never three stable samples in a row.
    for (int r = 0; r < 5; r++) begin
      vecs.push_back(mk(4'b0001, 4'b0000));
      vecs.push_back(mk(4'b0001, 4'b0000));
      vecs.push_back(mk(4'b0000, 4'b0000));
    end
    // Key 2 with a one-sample release glitch at long_cnt=4.
    for (int i = 1; i <= 14; i++)
      vecs.push_back(mk((i == 8) ? 4'b0000 : 4'b0100, (i >= 3) ? 4'b0100 : 4'b0000,
                        (i == 3 || i == 11) ? 1 : 0, 2'd2, (i == 3) ? T_PRESS : T_LONG));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(4'b0000, (i == 3) ? 4'b0000 : 4'b0100, (i == 3) ? 1 : 0, 2'd2, T_REL));

    foreach (vecs[j]) run_vec(vecs[j], 1'b1, $sformatf("row%0d", j));

    // Keys 1 and 3 together: both events in one scan, key 1 first.
    run_vec(mk(4'b1010, 4'b0000), 1'b1, "simul1");
    run_vec(mk(4'b1010, 4'b0000), 1'b1, "simul2");
    run_vec(mk(4'b1010, 4'b1010, 2, 2'd1, T_PRESS, 2'd3, T_PRESS), 1'b1, "simul3");
    chk("simul gap", pop_ph[3] - pop_ph[1], 2);
    run_vec(mk(4'b0000, 4'b1010), 1'b1, "simrel1");
    run_vec(mk(4'b0000, 4'b1010), 1'b1, "simrel2");
    run_vec(mk(4'b0000, 4'b0000, 2, 2'd1, T_REL, 2'd3, T_REL), 1'b1, "simrel3");

    // Consumer stalled while six events arrive: four queue, two drop.
    ev_ready = 1'b0;
    run_vec(mk(4'b0111, 4'b0000), 1'b0, "full1");
    run_vec(mk(4'b0111, 4'b0000), 1'b0, "full2");
    run_vec(mk(4'b0111, 4'b0111), 1'b0, "full3");
    chk("drop before full", 32'(ev_drop), 0);
    chk("valid stalled", 32'(ev_valid), 1);
    run_vec(mk(4'b0000, 4'b0111), 1'b0, "full4");
    run_vec(mk(4'b0000, 4'b0111), 1'b0, "full5");
    run_vec(mk(4'b0000, 4'b0000), 1'b0, "full6");
    chk("drop after overflow", 32'(ev_drop), 1);
    for (int i = 0; i < 3; i++) begin
      chk("head key hold", 32'(ev_key), 0);
      chk("head type hold", 32'(ev_type), 32'(T_PRESS));
      @(negedge clk);
      #3;
    end
    sb.push_back('{key: 2'd0, typ: T_PRESS});
    sb.push_back('{key: 2'd1, typ: T_PRESS});
    sb.push_back('{key: 2'd2, typ: T_PRESS});
    sb.push_back('{key: 2'd0, typ: T_REL});
    @(negedge clk);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("burst valid%0d", i), 32'(ev_valid), 1);
      @(negedge clk);
    end
    #3;
    chk("burst empty", 32'(ev_valid), 0);
    chk("burst drained", sb.size(), 0);

    // Reset with keys 1,2 pressed and two events queued.
    ev_ready = 1'b0;
    run_vec(mk(4'b0110, 4'b0000), 1'b0, "rst1");
    run_vec(mk(4'b0110, 4'b0000), 1'b0, "rst2");
    run_vec(mk(4'b0110, 4'b0110), 1'b0, "rst3");
    chk("two queued", 32'(ev_valid), 1);
    while (ph % 8 != 2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset level", 32'(lvl), 0);
    chk("midreset valid", 32'(ev_valid), 0);
    chk("midreset key", 32'(ev_key), 0);
    chk("midreset type", 32'(ev_type), 0);
    chk("midreset drop", 32'(ev_drop), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    run_vec(mk(4'b0110, 4'b0000), 1'b1, "post1");
    run_vec(mk(4'b0110, 4'b0000), 1'b1, "post2");
    run_vec(mk(4'b0110, 4'b0110, 2, 2'd1, T_PRESS, 2'd2, T_PRESS), 1'b1, "post3");
    run_vec(mk(4'b0000, 4'b0110), 1'b1, "postrel1");
    run_vec(mk(4'b0000, 4'b0110), 1'b1, "postrel2");
    run_vec(mk(4'b0000, 4'b0000, 2, 2'd1, T_REL, 2'd2, T_REL), 1'b1, "postrel3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
